spi_fb_ctrl: RTL
================

SPI_FB_CTRL -- requirements
Module: spi_fb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, framebuffer word-address width.
REQ-002 SHALL have parameter PIX_W, default 15, pixel width (5:5:5 RGB, red in MSBs).
REQ-003 SHALL have clk  input  1  system clock (50 MHz); one clock, all logic on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have rx_valid  input  1  one-cycle pulse: SPI slave byte received.
REQ-006 SHALL have rx_data  input  8  received byte, valid with rx_valid.
REQ-007 SHALL have frame_end  input  1  one-cycle pulse on cs deassert.
REQ-008 SHALL have tx_data  output  8  byte loaded by SPI slave for the next transfer.
REQ-009 SHALL have fb_wr_valid  output  1  framebuffer write request.
REQ-010 SHALL have fb_wr_ready  input  1  framebuffer accepts request this cycle.
REQ-011 SHALL have fb_wr_addr  output  ADDR_W  write word address.
REQ-012 SHALL have fb_wr_data  output  PIX_W  write pixel.
REQ-013 SHALL have led  output  8  LED register.
REQ-014 SHALL have err_cnt  output  8  protocol error count.

Function
REQ-015 SHALL decode the first byte of each frame as opcode: 0x01 PIXEL, 0x02 BURST, 0x03 LED; other values are errors.
REQ-016 SHALL use states IDLE, ADDR_H, ADDR_L, DAT_H, DAT_L, WRITE, LED, DISCARD.
REQ-017 SHALL, for PIXEL/BURST, go IDLE->ADDR_H->ADDR_L->DAT_H->DAT_L->WRITE, one byte per step; addr = {ADDR_H,ADDR_L} truncated to ADDR_W; pixel = {DAT_H,DAT_L}[PIX_W-1:0].
REQ-018 SHALL assert fb_wr_valid in the cycle after the DAT_L byte and hold fb_wr_valid, addr and data stable until the cycle fb_wr_ready is high.
REQ-019 SHALL, on acceptance, return PIXEL to DISCARD and BURST to DAT_H with address incremented by 1, wrapping all-ones to 0.
REQ-020 SHALL, for LED, load the next byte into led and go to DISCARD.
REQ-021 SHALL in DISCARD ignore bytes until frame_end, without error.
REQ-022 SHALL, on an unknown opcode, increment err_cnt and enter DISCARD.
REQ-023 SHALL, on rx_valid while in WRITE, drop the byte and increment err_cnt.
REQ-024 SHALL, on frame_end in any state but WRITE, return to IDLE next cycle and discard partial fields.
REQ-025 SHALL, on frame_end in WRITE, complete the pending write, then enter IDLE.
REQ-026 SHALL, on frame_end and rx_valid together, process the byte first, then apply frame_end.
REQ-027 SHALL saturate err_cnt at 0xFF.

Reset
REQ-028 SHALL on rst_n low immediately set state IDLE, fb_wr_valid 0, fb_wr_addr 0, fb_wr_data 0, led 0x00, err_cnt 0, tx_data 0x00.
REQ-029 SHALL drop any in-flight write on reset, with no handshake completion.

Configuration
REQ-030 SHALL, with SPI_FB_CTRL_STATUS_EN defined, drive tx_data = {fb_wr_valid, err_cnt[6:0]}, registered, updated every cycle.
REQ-031 SHALL, without SPI_FB_CTRL_STATUS_EN, tie tx_data to 0x00.

Structure
REQ-032 SHALL place opcode constants, state encoding and the PIX_W default in shared package vga_pkg.
REQ-033 SHALL be a single module; no sub-module needed.

Verification
REQ-034 SHALL cover PIXEL 01 12 34 7F FF, fb_wr_ready=1 -> one write, addr 0x1234, data 0x7FFF, fb_wr_valid high exactly one cycle.
REQ-035 SHALL cover BURST 02 FF FF 00 01 00 02, frame_end -> writes (0xFFFF,0x0001) then (0x0000,0x0002).
REQ-036 SHALL cover LED 03 AA 33 -> led=0xAA; 0x33 ignored; err_cnt unchanged.
REQ-037 SHALL cover opcode 0xFF then 00, frame_end -> err_cnt=1, no write, led unchanged.
REQ-038 SHALL cover fb_wr_ready low 10 cycles, byte plus frame_end during WRITE -> write held stable then completes once, err_cnt=1, state IDLE.
REQ-039 SHALL cover rst_n low after 01 12 -> all outputs reset immediately; next frame 01 00 05 00 09 writes addr 0x0005 data 0x0009.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the SPI framebuffer controller: opcodes, FSM state
// encoding and the default pixel width.
package vga_pkg;

  localparam int PIX_W_DEF = 15;

  localparam logic [7:0] OP_PIXEL = 8'h01;
  localparam logic [7:0] OP_BURST = 8'h02;
  localparam logic [7:0] OP_LED   = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_DAT_H,
    S_DAT_L,
    S_WRITE,
    S_LED,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/spi_fb_ctrl.sv
// SPI byte-stream decoder driving framebuffer pixel writes and an LED register.
// Define SPI_FB_CTRL_STATUS_EN to return {fb_wr_valid, err_cnt[6:0]} on tx_data.
module spi_fb_ctrl
  import vga_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              frame_end,
  output logic [7:0]        tx_data,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [PIX_W-1:0]  fb_wr_data,
  output logic [7:0]        led,
  output logic [7:0]        err_cnt
);

  state_t              state_q, state_d;
  logic                burst_q, burst_d;
  logic                fe_pend_q, fe_pend_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic [7:0]          led_q, led_d;
  logic [7:0]          err_q, err_d;
  logic [7:0]          tx_q, tx_d;
  logic                err_inc;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    fe_pend_d = fe_pend_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    data_d    = data_q;
    led_d     = led_q;
    err_inc   = 1'b0;

    case (state_q)
      S_IDLE: if (rx_valid) begin
        case (rx_data)
          OP_PIXEL: begin burst_d = 1'b0; state_d = S_ADDR_H; end
          OP_BURST: begin burst_d = 1'b1; state_d = S_ADDR_H; end
          OP_LED:   state_d = S_LED;
          default:  begin err_inc = 1'b1; state_d = S_DISCARD; end
        endcase
      end
      S_ADDR_H: if (rx_valid) begin hi_d = rx_data; state_d = S_ADDR_L; end
      S_ADDR_L: if (rx_valid) begin
        addr_d  = ADDR_W'({hi_q, rx_data});
        state_d = S_DAT_H;
      end
      S_DAT_H: if (rx_valid) begin hi_d = rx_data; state_d = S_DAT_L; end
      S_DAT_L: if (rx_valid) begin
        data_d  = PIX_W'({hi_q, rx_data});
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Bytes arriving while a write is outstanding have nowhere to go.
        if (rx_valid) err_inc = 1'b1;
        if (fb_wr_ready) begin
          fe_pend_d = 1'b0;
          if (fe_pend_q || frame_end) state_d = S_IDLE;
          else if (burst_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_DAT_H;
          end else state_d = S_DISCARD;
        end else if (frame_end) fe_pend_d = 1'b1;
      end
      S_LED: if (rx_valid) begin led_d = rx_data; state_d = S_DISCARD; end
      S_DISCARD: ;
      default: state_d = S_IDLE;
    endcase

    // The byte is consumed first; a frame ending on the last pixel byte
    // still owes its write, so it is remembered instead of aborting.
    if (frame_end && state_q != S_WRITE) begin
      if (state_d == S_WRITE) fe_pend_d = 1'b1;
      else                    state_d   = S_IDLE;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

`ifdef SPI_FB_CTRL_STATUS_EN
    tx_d = {fb_wr_valid, err_q[6:0]};
`else
    tx_d = 8'h00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      burst_q   <= 1'b0;
      fe_pend_q <= 1'b0;
      hi_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      led_q     <= '0;
      err_q     <= '0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      fe_pend_q <= fe_pend_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      led_q     <= led_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
    end
  end

  assign fb_wr_valid = (state_q == S_WRITE);
  assign fb_wr_addr  = addr_q;
  assign fb_wr_data  = data_q;
  assign led         = led_q;
  assign err_cnt     = err_q;
  assign tx_data     = tx_q;

endmodule
